// File: rtl/loader_pkg.sv
// Shared types for the byte-stream to BRAM loader: FSM states and write-strobe constants.
package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [3:0] WSTRB_ALL  = 4'hF;
  localparam logic [3:0] WSTRB_NONE = 4'h0;

  // Address width for a RAM of the given depth, never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/loader_packer.sv
// Little-endian byte-to-word assembler; word_ready flags the 4th byte in the same cycle it is accepted.
// No internal buffering: the caller gates acceptance through enable.
module loader_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_ready,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] shreg;
  logic        accept;

  assign accept     = in_valid && enable;
  // Earlier bytes slide toward bit 0, so the first byte lands in word[7:0].
  assign word       = {in_data, shreg};
  assign word_ready = accept && (byte_cnt == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      shreg    <= '0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      shreg    <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= word[31:8];
    end
  end

endmodule

// File: rtl/bram_loader.sv
// Loads LOAD_WORDS little-endian words from a byte stream into a RAM, one held write request per word.
// Minimum 5 cycles per word; in_ready drops while a write is pending. LOADER_CHECKSUM_EN adds a running word sum.
module bram_loader
  import loader_pkg::*;
#(
  parameter int  WORDS      = 256,
  parameter int  LOAD_WORDS = 256,
  localparam int AW         = addr_width(WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  output logic          busy,
  output logic          done,
  output logic [31:0]   checksum
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(LOAD_WORDS - 1);

  state_t      state;
  logic        load_start;
  logic        word_ready;
  logic [31:0] packed_word;

  assign load_start = start && ((state == ST_IDLE) || (state == ST_DONE));

  loader_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_start),
    .enable     (in_ready),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .word_ready (word_ready),
    .word       (packed_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= WSTRB_NONE;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_COLLECT;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            mem_addr <= '0;
          end
        end
        ST_COLLECT: begin
          if (word_ready) begin
            state     <= ST_WRITE;
            in_ready  <= 1'b0;
            mem_valid <= 1'b1;
            mem_wdata <= packed_word;
            mem_wstrb <= WSTRB_ALL;
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wstrb <= WSTRB_NONE;
            if (mem_addr == LAST_ADDR) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              mem_addr <= mem_addr + AW'(1);
              state    <= ST_COLLECT;
              in_ready <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic write_done;
  assign write_done = (state == ST_WRITE) && mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (load_start) begin
      checksum <= '0;
    end else if (write_done) begin
      checksum <= checksum + mem_wdata;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_bram_loader.sv
// Bench for bram_loader: constant word table, randomized byte/responder timing against a word-level model,
// and hand sequences for reset, start handling and the single-word configuration.
module tb_bram_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, in_valid, mem_ready;
  logic [7:0]  in_data;
  logic        in_ready, mem_valid, busy, done;
  logic [1:0]  mem_addr;
  logic [31:0] mem_wdata, checksum;
  logic [3:0]  mem_wstrb;

  logic        start1, in_valid1, mem_ready1;
  logic [7:0]  in_data1;
  logic        in_ready1, mem_valid1, busy1, done1;
  logic [1:0]  mem_addr1;
  logic [31:0] mem_wdata1, checksum1;
  logic [3:0]  mem_wstrb1;

  always #5 clk = ~clk;

  bram_loader #(.WORDS(4), .LOAD_WORDS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .busy(busy), .done(done), .checksum(checksum)
  );

  bram_loader #(.WORDS(4), .LOAD_WORDS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .mem_valid(mem_valid1), .mem_ready(mem_ready1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_wstrb(mem_wstrb1), .busy(busy1), .done(done1), .checksum(checksum1)
  );

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          addr;
    logic [31:0] wdata;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  tx[$];
  logic [7:0]  acc[$];
  logic [31:0] wr_data[$];
  int          wr_addr[$];
  int          vld_len[$];
  int          wait_len[$];
  int          viol;
  int          total_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference: word i is bytes 4i..4i+3 little-endian at address i.
  function automatic logic [31:0] model_word(input int i);
    return {tx[4*i+3], tx[4*i+2], tx[4*i+1], tx[4*i]};
  endfunction

  function automatic logic [31:0] model_cksum(input int n);
    logic [31:0] s = 32'h0;
`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < n; i++) s = s + model_word(i);
`endif
    return s;
  endfunction

  function automatic logic [31:0] wr_data_at(input int i);
    return (i < wr_data.size()) ? wr_data[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] wr_addr_at(input int i);
    return (i < wr_addr.size()) ? wr_addr[i] : 32'hxxxxxxxx;
  endfunction

  // Drives bytes from tx and acts as the RAM responder; all decisions are made at negedges.
  task automatic run_load(input bit rand_valid, input int wait_mode, input int stop_bytes, input int start_mid);
    int idx = 0, cyc = 0, wcnt = 0, target = 0;
    bit in_write = 1'b0;
    logic [1:0]  cap_addr = '0;
    logic [31:0] cap_data = '0;
    acc.delete(); wr_data.delete(); wr_addr.delete(); vld_len.delete(); wait_len.delete();
    viol = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (1) begin
      in_valid = (idx < tx.size()) && (!rand_valid || ($urandom_range(0, 1) == 1));
      in_data  = (idx < tx.size()) ? tx[idx] : 8'h00;
      if (in_valid && in_ready) begin
        acc.push_back(in_data);
        idx++;
      end
      mem_ready = 1'b0;
      if (mem_valid) begin
        if (!in_write) begin
          in_write = 1'b1;
          wcnt     = 0;
          cap_addr = mem_addr;
          cap_data = mem_wdata;
          target   = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
        end
        if (mem_addr !== cap_addr || mem_wdata !== cap_data || in_ready !== 1'b0 || mem_wstrb !== 4'hF)
          viol++;
        if (wcnt == target) begin
          mem_ready = 1'b1;
          wr_addr.push_back(int'(mem_addr));
          wr_data.push_back(mem_wdata);
          vld_len.push_back(wcnt + 1);
          wait_len.push_back(target);
          in_write = 1'b0;
        end else begin
          wcnt++;
        end
      end
      start = (start_mid > 0 && cyc == start_mid);
      @(negedge clk);
      cyc++;
      if (done || acc.size() >= stop_bytes || cyc > 2000) break;
    end
    in_valid = 1'b0; mem_ready = 1'b0; start = 1'b0;
    total_cyc = cyc;
    chk("load_timeout", cyc > 2000, 0);
  endtask

  task automatic check_load(input string tag, input int n);
    int bad = 0;
    chk({tag, "_nwrites"}, wr_data.size(), n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, wr_addr_at(i), i);
      chk({tag, "_data"}, wr_data_at(i), model_word(i));
    end
    chk({tag, "_nbytes"}, acc.size(), tx.size());
    for (int i = 0; i < acc.size() && i < tx.size(); i++) if (acc[i] !== tx[i]) bad++;
    chk({tag, "_byte_order"}, bad, 0);
    chk({tag, "_write_stable"}, viol, 0);
    chk({tag, "_checksum"}, checksum, model_cksum(n));
    chk({tag, "_done"}, {done, busy, in_ready, mem_valid}, 4'b1000);
    chk({tag, "_wstrb_idle"}, mem_wstrb, 4'h0);
  endtask

  task automatic load_counting_bytes();
    tx.delete();
    for (int i = 1; i <= 16; i++) tx.push_back(8'(i));
  endtask

  initial begin
    vec_t tbl [4];
    logic [7:0] b1 [4];
    logic [31:0] tsum;
    int bad, n1, a1, extra;
    logic [31:0] d1;

    tbl[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 0, 32'h04030201};
    tbl[1] = '{8'h05, 8'h06, 8'h07, 8'h08, 1, 32'h08070605};
    tbl[2] = '{8'h09, 8'h0A, 8'h0B, 8'h0C, 2, 32'h0C0B0A09};
    tbl[3] = '{8'h0D, 8'h0E, 8'h0F, 8'h10, 3, 32'h100F0E0D};
    b1[0] = 8'hAA; b1[1] = 8'hBB; b1[2] = 8'hCC; b1[3] = 8'hDD;

    reset = 1'b1; start = 0; in_valid = 0; in_data = 0; mem_ready = 0;
    start1 = 0; in_valid1 = 0; in_data1 = 0; mem_ready1 = 0;
    #12;
    chk("rst_flags", {in_ready, mem_valid, busy, done}, 4'b0000);
    chk("rst_wstrb", mem_wstrb, 4'h0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_checksum", checksum, 32'h0);
    @(negedge clk); reset = 1'b0;

    // Table-driven zero-wait load: exact words, addresses and 5-cycle-per-word timing.
    tx.delete();
    tsum = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tx.push_back(tbl[i].b0); tx.push_back(tbl[i].b1);
      tx.push_back(tbl[i].b2); tx.push_back(tbl[i].b3);
`ifdef LOADER_CHECKSUM_EN
      tsum = tsum + tbl[i].wdata;
`endif
    end
    run_load(1'b0, 0, 1000, 0);
    for (int i = 0; i < 4; i++) begin
      chk("tbl_addr", wr_addr_at(i), tbl[i].addr);
      chk("tbl_data", wr_data_at(i), tbl[i].wdata);
    end
    chk("tbl_checksum", checksum, tsum);
    chk("tbl_cycles", total_cyc, 20);
    check_load("zero_wait", 4);

    // Responder stalls three cycles per word.
    load_counting_bytes();
    run_load(1'b0, 3, 1000, 0);
    bad = 0;
    foreach (vld_len[i]) if (vld_len[i] != 4) bad++;
    chk("stall_valid_len", bad, 0);
    chk("stall_cycles", total_cyc, 32);
    check_load("stall", 4);

    // Random in_valid gaps and random responder waits.
    load_counting_bytes();
    run_load(1'b1, -1, 1000, 0);
    for (int i = 0; i < 4; i++) chk("rand_tbl_data", wr_data_at(i), tbl[i].wdata);
    check_load("rand_valid", 4);
    for (int r = 0; r < 3; r++) begin
      tx.delete();
      for (int i = 0; i < 16; i++) tx.push_back(8'($urandom));
      run_load(1'b1, -1, 1000, 0);
      check_load("rand_bytes", 4);
    end

    // start during COLLECT is ignored.
    load_counting_bytes();
    run_load(1'b0, 0, 1000, 2);
    chk("start_mid_cycles", total_cyc, 20);
    check_load("start_mid", 4);

    // start in DONE restarts from address 0.
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("restart_flags", {done, busy, in_ready}, 3'b011);
    chk("restart_addr", mem_addr, 0);
    chk("restart_checksum", checksum, 32'h0);
    run_load(1'b0, 0, 1000, 0);
    check_load("restart", 4);

    // Reset after two bytes of word 1.
    load_counting_bytes();
    run_load(1'b0, 0, 6, 0);
    chk("prerst_writes", wr_data.size(), 1);
    chk("prerst_state", {busy, in_ready, 30'(mem_addr)}, {2'b11, 30'd1});
    #2 reset = 1'b1;
    #1;
    chk("arst_flags", {in_ready, mem_valid, busy, done}, 4'b0000);
    chk("arst_addr", mem_addr, 0);
    chk("arst_wdata", mem_wdata, 32'h0);
    chk("arst_wstrb", mem_wstrb, 4'h0);
    chk("arst_checksum", checksum, 32'h0);
    @(negedge clk); reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      if (mem_valid || busy) extra++;
    end
    mem_ready = 1'b0;
    chk("postrst_no_write", extra, 0);
    run_load(1'b0, 0, 1000, 0);
    check_load("reload", 4);

    // Single-word configuration; mem_ready in IDLE has no effect.
    mem_ready1 = 1'b1;
    @(negedge clk); mem_ready1 = 1'b0;
    @(negedge clk);
    chk("one_idle_flags", {busy1, done1, in_ready1, mem_valid1}, 4'b0000);
    chk("one_idle_addr", mem_addr1, 0);
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; mem_ready1 = 1'b1;
    n1 = 0; a1 = -1; d1 = 32'h0;
    begin
      int bidx = 0;
      for (int c = 0; c < 40; c++) begin
        in_valid1 = (bidx < 4);
        in_data1  = (bidx < 4) ? b1[bidx] : 8'h00;
        if (in_valid1 && in_ready1) bidx++;
        if (mem_valid1 && mem_ready1) begin
          n1++; a1 = int'(mem_addr1); d1 = mem_wdata1;
        end
        @(negedge clk);
        if (done1) break;
      end
    end
    in_valid1 = 1'b0;
    chk("one_nwrites", n1, 1);
    chk("one_addr", a1, 0);
    chk("one_data", d1, 32'hDDCCBBAA);
`ifdef LOADER_CHECKSUM_EN
    chk("one_checksum", checksum1, 32'hDDCCBBAA);
`else
    chk("one_checksum", checksum1, 32'h0);
`endif
    repeat (3) @(negedge clk);
    chk("one_done_hold", {done1, busy1, mem_valid1}, 3'b100);
    mem_ready1 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
